// File: rtl/demux4x32_stream_if.sv
// Stream bundle for demux4x32_stream: one producer-side input word plus
// N_OUTPUTS consumer-side output slots with their delivered-word counters.
interface demux4x32_stream_if #(
  parameter int N_OUTPUTS   = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
);
  localparam int SEL_WIDTH = (N_OUTPUTS > 1) ? $clog2(N_OUTPUTS) : 1;

  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_WIDTH-1:0]            in_data;
  logic [SEL_WIDTH-1:0]             in_sel;
  logic                             in_bcast;
  logic [N_OUTPUTS-1:0]             out_valid;
  logic [N_OUTPUTS-1:0]             out_ready;
  logic [N_OUTPUTS*DATA_WIDTH-1:0]  out_data;
  logic [N_OUTPUTS*COUNT_WIDTH-1:0] out_count;
  logic                             sel_err;

  // master is the producer/consumer environment, slave is the demux itself
  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, out_count, sel_err
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, out_count, sel_err
  );
endinterface

// File: rtl/demux4x32_stream.sv
// 1-to-N registered stream demultiplexer: each input word goes to one channel
// (or every channel on broadcast), each channel holding one word behind valid/ready.
module demux4x32_stream #(
  parameter int N_OUTPUTS   = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input logic               clk,
  input logic               reset,
  demux4x32_stream_if.slave bus
);
  logic [N_OUTPUTS-1:0]                  valid_q, valid_d;
  logic [N_OUTPUTS-1:0][DATA_WIDTH-1:0]  data_q, data_d;
  logic [N_OUTPUTS-1:0][COUNT_WIDTH-1:0] count_q, count_d;
  logic                                  sel_err_q, sel_err_d;

  logic [N_OUTPUTS-1:0] chan_free;
  logic [N_OUTPUTS-1:0] chan_drain;
  logic [N_OUTPUTS-1:0] sel_hit;
  logic [N_OUTPUTS-1:0] chan_target;
  logic [N_OUTPUTS-1:0] chan_load;
  logic                 sel_in_range;
  logic                 in_ready_c;
  logic                 accept;

  // A slot is free when empty or being emptied this cycle, which lets a new
  // word replace a departing one for full per-channel throughput.
  always_comb begin
    chan_free  = ~valid_q | bus.out_ready;
    chan_drain = valid_q & bus.out_ready;
    sel_hit    = '0;
    for (int i = 0; i < N_OUTPUTS; i++) begin
      sel_hit[i] = (int'(bus.in_sel) == i);
    end
    sel_in_range = |sel_hit;
    chan_target  = bus.in_bcast ? {N_OUTPUTS{1'b1}} : sel_hit;
  end

  // Out-of-range unicast is always accepted so the producer never stalls on it.
  always_comb begin
    in_ready_c = 1'b1;
    if (reset) begin
      in_ready_c = 1'b0;
    end else if (bus.in_bcast) begin
      in_ready_c = &chan_free;
    end else if (sel_in_range) begin
      in_ready_c = |(sel_hit & chan_free);
    end
    accept    = bus.in_valid && in_ready_c;
    chan_load = accept ? chan_target : '0;
    sel_err_d = accept && !bus.in_bcast && !sel_in_range;
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    for (int i = 0; i < N_OUTPUTS; i++) begin
      valid_d[i] = chan_load[i] | (valid_q[i] & ~chan_drain[i]);
      if (chan_load[i]) begin
        data_d[i] = bus.in_data;
      end
      count_d[i] = count_q[i] + {{(COUNT_WIDTH-1){1'b0}}, chan_drain[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      data_q    <= '0;
      count_q   <= '0;
      sel_err_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      count_q   <= count_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_count = count_q;
  assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_demux4x32_stream.sv
// Self-checking bench for demux4x32_stream: directed scenarios plus random
// traffic on a 4x32 instance against a slot model, and a 3-channel, 4-bit-count instance for edge cases.
module tb_demux4x32_stream;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  demux4x32_stream_if #(.N_OUTPUTS(N), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus_a ();
  demux4x32_stream #(.N_OUTPUTS(N), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  demux4x32_stream_if #(.N_OUTPUTS(3), .DATA_WIDTH(8), .COUNT_WIDTH(4)) bus_b ();
  demux4x32_stream #(.N_OUTPUTS(3), .DATA_WIDTH(8), .COUNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  // Reference: each channel is a one-word slot; counts are delivered words mod 2^CW.
  bit          m_valid [N];
  logic [DW-1:0] m_data [N];
  int unsigned m_count [N];
  bit          m_sel_err;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkState();
    logic [N-1:0] exp_valid;
    for (int i = 0; i < N; i++) exp_valid[i] = m_valid[i];
    checkOutput("out_valid", bus_a.out_valid, exp_valid);
    checkOutput("sel_err", bus_a.sel_err, m_sel_err);
    for (int i = 0; i < N; i++) begin
      if (m_valid[i]) checkOutput($sformatf("out_data[%0d]", i), bus_a.out_data[i*DW +: DW], m_data[i]);
      checkOutput($sformatf("out_count[%0d]", i), bus_a.out_count[i*CW +: CW], m_count[i]);
    end
  endtask

  // Called just after a rising edge; drives one cycle, checks in_ready, advances model and DUT.
  task automatic applyStimulus(input bit v, input bit bcast, input int sel,
                               input logic [DW-1:0] d, input logic [N-1:0] rdy);
    bit exp_ready;
    bit accept;
    bus_a.in_valid  = v;
    bus_a.in_bcast  = bcast;
    bus_a.in_sel    = 2'(sel);
    bus_a.in_data   = d;
    bus_a.out_ready = rdy;
    #1;
    if (reset) begin
      exp_ready = 1'b0;
    end else if (bcast) begin
      exp_ready = 1'b1;
      for (int i = 0; i < N; i++) if (m_valid[i] && !rdy[i]) exp_ready = 1'b0;
    end else if (sel < N) begin
      exp_ready = !m_valid[sel] || rdy[sel];
    end else begin
      exp_ready = 1'b1;
    end
    checkOutput("in_ready", bus_a.in_ready, exp_ready);
    accept    = v && exp_ready;
    m_sel_err = accept && !bcast && (sel >= N);
    for (int i = 0; i < N; i++) begin
      bit delivered;
      delivered = m_valid[i] && rdy[i];
      if (delivered) m_count[i] = (m_count[i] + 1) % (1 << CW);
      if (accept && (bcast || sel == i)) begin
        m_valid[i] = 1'b1;
        m_data[i]  = d;
      end else if (delivered) begin
        m_valid[i] = 1'b0;
      end
    end
    if (reset) begin
      m_sel_err = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_valid[i] = 1'b0;
        m_data[i]  = '0;
        m_count[i] = 0;
      end
    end
    @(posedge clk);
    #1;
    checkState();
  endtask

  task automatic stepB(input bit v, input int sel, input logic [7:0] d, input logic [2:0] rdy);
    bus_b.in_valid  = v;
    bus_b.in_bcast  = 1'b0;
    bus_b.in_sel    = 2'(sel);
    bus_b.in_data   = d;
    bus_b.out_ready = rdy;
    #1;
    if (v) checkOutput("b_in_ready", bus_b.in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_bcast = 1'b0; bus_b.in_sel = '0;
    bus_b.in_data = '0; bus_b.out_ready = '0;
    applyStimulus(0, 0, 2, '0, 4'b0000);
    applyStimulus(0, 0, 2, '0, 4'b0000);
    reset = 1'b0;

    // Reset state and readiness toward channel 2.
    checkOutput("rst_out_data", bus_a.out_data[63:0], 64'h0);
    applyStimulus(0, 0, 2, '0, 4'b1111);

    // Unicast with one-cycle latency, counted once drained.
    applyStimulus(1, 0, 2, 32'hDEADBEEF, 4'b1111);
    checkOutput("uni_valid", bus_a.out_valid, 4'b0100);
    checkOutput("uni_data", bus_a.out_data[2*DW +: DW], 32'hDEADBEEF);
    applyStimulus(0, 0, 0, '0, 4'b1111);
    checkOutput("uni_count", bus_a.out_count[2*CW +: CW], 16'd1);

    // Backpressure on ch1 must not block a unicast to ch3.
    applyStimulus(1, 0, 1, 32'h11, 4'b1101);
    applyStimulus(1, 0, 1, 32'h22, 4'b1101);
    checkOutput("bp_hold", bus_a.out_data[1*DW +: DW], 32'h11);
    applyStimulus(1, 0, 3, 32'h33, 4'b0101);
    checkOutput("bp_other", bus_a.out_data[3*DW +: DW], 32'h33);
    applyStimulus(0, 0, 0, '0, 4'b1111);

    // Streaming: one word per cycle into ch0, in order.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 0, 0, DW'(k), 4'b1111);
      checkOutput("stream_data", bus_a.out_data[DW-1:0], DW'(k));
    end
    applyStimulus(0, 0, 0, '0, 4'b1111);
    checkOutput("stream_count", bus_a.out_count[CW-1:0], 16'd8);

    // Broadcast is all-or-nothing.
    applyStimulus(1, 0, 2, 32'h55, 4'b1011);
    applyStimulus(1, 1, 0, 32'hA5A5A5A5, 4'b1011);
    checkOutput("bc_blocked_data", bus_a.out_data[2*DW +: DW], 32'h55);
    applyStimulus(1, 1, 0, 32'hA5A5A5A5, 4'b1111);
    checkOutput("bc_valid", bus_a.out_valid, 4'b1111);
    for (int i = 0; i < N; i++) checkOutput("bc_data", bus_a.out_data[i*DW +: DW], 32'hA5A5A5A5);

    // Reset while channels are stalled discards held words.
    applyStimulus(1, 0, 0, 32'h77, 4'b0000);
    reset = 1'b1;
    applyStimulus(1, 0, 1, 32'h88, 4'b0000);
    checkOutput("mid_rst_valid", bus_a.out_valid, 4'b0000);
    reset = 1'b0;

    // Random traffic against the slot model.
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                    int'($urandom_range(0, N-1)), DW'($urandom), 4'($urandom));
    end
    bus_a.in_valid = 1'b0;

    // Narrow-count instance: 17 deliveries on ch0 wrap a 4-bit counter to 1.
    for (int k = 0; k < 17; k++) stepB(1, 0, 8'(k), 3'b001);
    stepB(0, 0, 8'h00, 3'b001);
    checkOutput("b_wrap_count", bus_b.out_count[3:0], 4'd1);

    // Out-of-range select on a 3-channel instance: dropped, one-cycle sel_err.
    stepB(1, 3, 8'h99, 3'b000);
    checkOutput("b_sel_err", bus_b.sel_err, 1'b1);
    checkOutput("b_drop_valid", bus_b.out_valid, 3'b000);
    stepB(0, 0, 8'h00, 3'b000);
    checkOutput("b_sel_err_clear", bus_b.sel_err, 1'b0);
    checkOutput("b_count_kept", bus_b.out_count[3:0], 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
